// File: rtl/wb_bus_rr_interconnect.sv
`default_nettype none
// =============================================================================
// Module   : wb_bus_rr_interconnect
// Brief    : Shared-bus Wishbone B3 interconnect with a registered round-robin grant,
//            mask/base address decode and error on decode miss. Defining
//            WB_BUS_WATCHDOG_EN adds a per-transfer watchdog.
// Revision : 1.0
// =============================================================================
module wb_bus_rr_interconnect #(
    parameter int                   MASTERS = 3,
    parameter int                   SLAVES  = 3,
    parameter int                   DW      = 32,
    parameter int                   AW      = 32,
    parameter logic [SLAVES*AW-1:0] S_BASE  = {32'hF000_0000, 32'hE000_0000, 32'h0000_0000},
    parameter logic [SLAVES*AW-1:0] S_MASK  = {32'hF000_0000, 32'hF000_0000, 32'h8000_0000},
    parameter int                   TIMEOUT = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [MASTERS*AW-1:0]     m_adr_i,
    input  logic [MASTERS*DW-1:0]     m_dat_i,
    input  logic [MASTERS*(DW/8)-1:0] m_sel_i,
    input  logic [MASTERS-1:0]        m_we_i,
    input  logic [MASTERS-1:0]        m_cyc_i,
    input  logic [MASTERS-1:0]        m_stb_i,
    output logic [MASTERS*DW-1:0]     m_dat_o,
    output logic [MASTERS-1:0]        m_ack_o,
    output logic [MASTERS-1:0]        m_err_o,
    output logic [AW-1:0]             s_adr_o,
    output logic [DW-1:0]             s_dat_o,
    output logic [DW/8-1:0]           s_sel_o,
    output logic                      s_we_o,
    output logic [SLAVES-1:0]         s_cyc_o,
    output logic [SLAVES-1:0]         s_stb_o,
    input  logic [SLAVES*DW-1:0]      s_dat_i,
    input  logic [SLAVES-1:0]         s_ack_i,
    input  logic [SLAVES-1:0]         s_err_i
);

    localparam int SW = DW / 8;
    localparam int MW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [MASTERS-1:0] gnt_q, gnt_d;
    logic [MW-1:0]      last_q, last_d;
    logic               miss_q, miss_d;
    logic               wdog_q;
    logic               w_fire;

    logic [AW-1:0]      own_adr;
    logic [DW-1:0]      own_dat;
    logic [SW-1:0]      own_sel;
    logic               own_we, own_cyc, own_stb;
    logic [SLAVES-1:0]  dec;
    logic               sel_ack, sel_err;
    logic [DW-1:0]      sel_dat;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            last_q  <= MW'(MASTERS - 1);
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            miss_q  <= miss_d;
        end
    end

    // Next-state: rotate search starting just after the previous owner
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        if (state_q == ST_IDLE || !own_cyc) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            for (int k = MASTERS; k >= 1; k--) begin
                if (m_cyc_i[(int'(last_q) + k) % MASTERS]) begin
                    gnt_d                                  = '0;
                    gnt_d[(int'(last_q) + k) % MASTERS]    = 1'b1;
                    last_d                                 = MW'((int'(last_q) + k) % MASTERS);
                    state_d                                = ST_OWNED;
                end
            end
        end
    end

    // Output: owner mux, decode and response routing
    always_comb begin
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        own_we  = 1'b0;
        own_cyc = 1'b0;
        own_stb = 1'b0;
        for (int i = 0; i < MASTERS; i++) begin
            if (gnt_q[i]) begin
                own_adr = own_adr | m_adr_i[i*AW +: AW];
                own_dat = own_dat | m_dat_i[i*DW +: DW];
                own_sel = own_sel | m_sel_i[i*SW +: SW];
                own_we  = own_we  | m_we_i[i];
                own_cyc = own_cyc | m_cyc_i[i];
                own_stb = own_stb | m_stb_i[i];
            end
        end

        dec = '0;
        if (state_q == ST_OWNED) begin
            for (int j = SLAVES - 1; j >= 0; j--) begin
                if ((own_adr & S_MASK[j*AW +: AW]) == S_BASE[j*AW +: AW]) begin
                    dec    = '0;
                    dec[j] = 1'b1;
                end
            end
        end

        sel_ack = 1'b0;
        sel_err = 1'b0;
        sel_dat = '0;
        for (int j = 0; j < SLAVES; j++) begin
            if (dec[j]) begin
                sel_ack = s_ack_i[j];
                sel_err = s_err_i[j];
                sel_dat = s_dat_i[j*DW +: DW];
            end
        end
    end

    assign miss_d  = own_stb & ~(|dec) & ~miss_q;

    assign s_adr_o = own_adr;
    assign s_dat_o = own_dat;
    assign s_sel_o = own_sel;
    assign s_we_o  = own_we;
    assign s_cyc_o = {SLAVES{own_cyc}} & dec;
    assign s_stb_o = {SLAVES{own_stb & ~w_fire}} & dec;
    assign m_dat_o = {MASTERS{sel_dat}};
    assign m_ack_o = gnt_q & {MASTERS{sel_ack}};
    assign m_err_o = gnt_q & {MASTERS{sel_err | miss_q | wdog_q}};

`ifdef WB_BUS_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          wdog_d, w_inc;

    assign w_inc  = own_stb & (|dec) & ~sel_ack & ~sel_err;
    assign w_fire = w_inc & (wcnt_q == CW'(TIMEOUT - 1));
    assign wdog_d = w_fire;

    always_comb begin
        wcnt_d = wcnt_q + 1'b1;
        if ((gnt_d != gnt_q) || w_fire || !w_inc) begin
            wcnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wcnt_q <= '0;
            wdog_q <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            wdog_q <= wdog_d;
        end
    end
`else
    assign w_fire = 1'b0;
    assign wdog_q = 1'b0;

    // TIMEOUT has no effect without the watchdog
    if (TIMEOUT < 2) begin : g_no_watchdog
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_bus_rr_interconnect.sv
`default_nettype none
// =============================================================================
// Module   : tb_wb_bus_rr_interconnect
// Brief    : Directed and randomized bench for wb_bus_rr_interconnect with an
//            index-level reference model of grant, decode, miss and watchdog.
// Revision : 1.0
// =============================================================================
module tb_wb_bus_rr_interconnect;

    localparam int M   = 3;
    localparam int S   = 3;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 4;

    localparam logic [AW-1:0] BASE [S] = '{32'h0000_0000, 32'hE000_0000, 32'hF000_0000};
    localparam logic [AW-1:0] MASK [S] = '{32'h8000_0000, 32'hF000_0000, 32'hF000_0000};

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic [M*AW-1:0]   m_adr_i;
    logic [M*DW-1:0]   m_dat_i;
    logic [M*SW-1:0]   m_sel_i;
    logic [M-1:0]      m_we_i;
    logic [M-1:0]      m_cyc_i;
    logic [M-1:0]      m_stb_i;
    logic [M*DW-1:0]   m_dat_o;
    logic [M-1:0]      m_ack_o;
    logic [M-1:0]      m_err_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic [SW-1:0]     s_sel_o;
    logic              s_we_o;
    logic [S-1:0]      s_cyc_o;
    logic [S-1:0]      s_stb_o;
    logic [S*DW-1:0]   s_dat_i;
    logic [S-1:0]      s_ack_i;
    logic [S-1:0]      s_err_i;

    wb_bus_rr_interconnect #(
        .MASTERS (M),
        .SLAVES  (S),
        .DW      (DW),
        .AW      (AW),
        .TIMEOUT (TMO)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_sel_i (m_sel_i),
        .m_we_i  (m_we_i),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_we_o  (s_we_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i),
        .s_err_i (s_err_i)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, req);
        end
    endtask

    // Reference model: owner as a master index (-1 = none), slave chosen by index
    typedef struct {
        int  owner;
        int  last;
        int  cnt;
        bit  miss;
        bit  wdog;
    } mst_t;

    typedef struct {
        logic [M*DW-1:0] mdat;
        logic [M-1:0]    mack;
        logic [M-1:0]    merr;
        logic [AW-1:0]   sadr;
        logic [DW-1:0]   sdat;
        logic [SW-1:0]   ssel;
        logic            swe;
        logic [S-1:0]    scyc;
        logic [S-1:0]    sstb;
        int              sj;
        bit              inc;
        bit              fire;
    } exp_t;

    mst_t ms = '{owner: -1, last: M - 1, cnt: 0, miss: 1'b0, wdog: 1'b0};

    function automatic exp_t model_eval();
        exp_t          e;
        logic [AW-1:0] a;
        logic          ack, err, ostb, ocyc;
        logic [DW-1:0] d;
        e = '{default: 0};
        e.sj = -1;
        if (ms.owner >= 0) begin
            a    = m_adr_i[ms.owner*AW +: AW];
            ostb = m_stb_i[ms.owner];
            ocyc = m_cyc_i[ms.owner];
            for (int j = 0; j < S; j++)
                if (e.sj < 0 && (a & MASK[j]) == BASE[j]) e.sj = j;
            ack = 1'b0;
            err = 1'b0;
            d   = '0;
            if (e.sj >= 0) begin
                ack = s_ack_i[e.sj];
                err = s_err_i[e.sj];
                d   = s_dat_i[e.sj*DW +: DW];
            end
            e.sadr = a;
            e.sdat = m_dat_i[ms.owner*DW +: DW];
            e.ssel = m_sel_i[ms.owner*SW +: SW];
            e.swe  = m_we_i[ms.owner];
            e.inc  = ostb && (e.sj >= 0) && !ack && !err;
`ifdef WB_BUS_WATCHDOG_EN
            e.fire = e.inc && (ms.cnt == TMO - 1);
`endif
            if (e.sj >= 0) begin
                e.scyc[e.sj] = ocyc;
                e.sstb[e.sj] = ostb && !e.fire;
            end
            e.mdat = {M{d}};
            e.mack[ms.owner] = ack;
            e.merr[ms.owner] = err || ms.miss || ms.wdog;
        end
        return e;
    endfunction

    function automatic mst_t model_next();
        mst_t n;
        exp_t e;
        int   o;
        n = ms;
        e = model_eval();
        o = ms.owner;
        if (!rst_i) begin
            n = '{owner: -1, last: M - 1, cnt: 0, miss: 1'b0, wdog: 1'b0};
            return n;
        end
        if (o < 0 || !m_cyc_i[o]) begin
            n.owner = -1;
            for (int k = 1; k <= M; k++)
                if (n.owner < 0 && m_cyc_i[(ms.last + k) % M]) n.owner = (ms.last + k) % M;
            if (n.owner >= 0) n.last = n.owner;
        end
        n.miss = (o >= 0) && m_stb_i[o] && (e.sj < 0) && !ms.miss;
`ifdef WB_BUS_WATCHDOG_EN
        n.wdog = e.fire;
        n.cnt  = (n.owner != o || e.fire || !e.inc) ? 0 : ms.cnt + 1;
`else
        n.wdog = 1'b0;
        n.cnt  = 0;
`endif
        return n;
    endfunction

    always @(posedge clk_i) ms <= model_next();

    always @(negedge clk_i) begin
        exp_t e;
        if (chk_en) begin
            e = model_eval();
            chk("m_dat_o", m_dat_o, e.mdat);
            chk("m_ack_o", m_ack_o, e.mack);
            chk("m_err_o", m_err_o, e.merr);
            chk("s_adr_o", s_adr_o, e.sadr);
            chk("s_dat_o", s_dat_o, e.sdat);
            chk("s_sel_o", s_sel_o, e.ssel);
            chk("s_we_o",  s_we_o,  e.swe);
            chk("s_cyc_o", s_cyc_o, e.scyc);
            chk("s_stb_o", s_stb_o, e.sstb);
        end
    end

    function automatic logic [AW-1:0] rand_adr();
        case ($urandom_range(0, 3))
            0:       return {1'b0, 31'($urandom)};
            1:       return {4'hE, 28'($urandom)};
            2:       return {4'hF, 28'($urandom)};
            default: return {4'(8 + $urandom_range(0, 5)), 28'($urandom)};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int          seq[$];
        int          rr_exp[4];
        int          o;
        int          gaps;
        bit          started;
        logic [M-1:0] last_ack;
        logic [M-1:0] resp;
        logic [S-1:0] wexp_stb;
        logic [M-1:0] wexp_err;

        rr_exp   = '{0, 1, 2, 0};
        gaps     = 0;
        started  = 1'b0;
        last_ack = '0;

        m_adr_i = {32'h0000_0030, 32'h0000_0020, 32'h0000_0010};
        m_dat_i = '0;
        m_sel_i = '1;
        m_we_i  = '0;
        m_cyc_i = '1;
        m_stb_i = '1;
        s_dat_i = '0;
        s_ack_i = '0;
        s_err_i = '0;
        rst_i   = 1'b0;

        // Reset held with every master requesting
        tick();
        chk_en = 1'b1;
        @(negedge clk_i);
        chk("rst_m_ack", m_ack_o, 0);
        chk("rst_m_err", m_err_o, 0);
        chk("rst_s_cyc", s_cyc_o, 0);
        chk("rst_s_stb", s_stb_o, 0);
        chk("rst_s_adr", s_adr_o, 0);
        chk("rst_m_dat", m_dat_o, 0);
        tick();

        // Round robin: each master drops cyc for a cycle after its ack
        rst_i   = 1'b1;
        s_ack_i = 3'b001;
        for (int c = 0; c < 10; c++) begin
            m_cyc_i = ~last_ack;
            m_stb_i = ~last_ack;
            @(negedge clk_i);
            if (c == 1) chk("first_grant_m0", s_adr_o, 32'h10);
            o = (s_adr_o == 32'h10) ? 0 : (s_adr_o == 32'h20) ? 1 : (s_adr_o == 32'h30) ? 2 : -1;
            if (o >= 0) started = 1'b1;
            if (started && o < 0) gaps++;
            if (o >= 0 && (seq.size() == 0 || seq[$] != o)) seq.push_back(o);
            last_ack = m_ack_o;
            tick();
        end
        for (int k = 0; k < 4; k++)
            chk($sformatf("rr_order%0d", k), (seq.size() > k) ? seq[k] : -1, rr_exp[k]);
        chk("rr_no_idle", gaps, 0);

        m_cyc_i = '0;
        m_stb_i = '0;
        s_ack_i = '0;
        tick();
        tick();

        // Decode hit on slave 1
        m_adr_i[AW +: AW]    = 32'hE000_0010;
        s_dat_i[0 +: DW]     = 32'h1111_1111;
        s_dat_i[DW +: DW]    = 32'hCAFE_F00D;
        s_dat_i[2*DW +: DW]  = 32'h2222_2222;
        s_ack_i              = 3'b111;
        m_cyc_i              = 3'b010;
        m_stb_i              = 3'b010;
        tick();
        @(negedge clk_i);
        chk("dec_s_stb", s_stb_o, 3'b010);
        chk("dec_m_dat", m_dat_o, {3{32'hCAFE_F00D}});
        chk("dec_m_ack", m_ack_o, 3'b010);
        tick();
        m_cyc_i = '0;
        m_stb_i = '0;
        s_ack_i = '0;
        tick();
        tick();

        // Decode miss on m0
        m_adr_i[0 +: AW] = 32'h9000_0000;
        m_cyc_i          = 3'b001;
        m_stb_i          = 3'b001;
        tick();
        @(negedge clk_i);
        chk("miss_s_stb", s_stb_o, 0);
        chk("miss_err_c0", m_err_o, 0);
        tick();
        @(negedge clk_i);
        chk("miss_err_c1", m_err_o, 3'b001);
        tick();
        m_cyc_i = '0;
        m_stb_i = '0;
        @(negedge clk_i);
        chk("miss_err_c2", m_err_o, 0);
        tick();
        tick();

        // Silent slave 2
        m_adr_i[2*AW +: AW] = 32'hF000_0000;
        m_cyc_i             = 3'b100;
        m_stb_i             = 3'b100;
        tick();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk_i);
            wexp_err = '0;
            wexp_stb = 3'b100;
`ifdef WB_BUS_WATCHDOG_EN
            if (k == 4) wexp_err = 3'b100;
            if (k == 3) wexp_stb = '0;
`endif
            chk($sformatf("wdog_err_k%0d", k), m_err_o, wexp_err);
            chk($sformatf("wdog_stb_k%0d", k), s_stb_o, wexp_stb);
            tick();
        end
        m_cyc_i = '0;
        m_stb_i = '0;
        tick();
        tick();

        // Stray slave responses while idle
        s_ack_i = 3'b111;
        s_err_i = 3'b111;
        @(negedge clk_i);
        chk("stray_ack", m_ack_o, 0);
        chk("stray_err", m_err_o, 0);
        tick();
        s_ack_i = '0;
        s_err_i = '0;

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk_i);
            resp = m_ack_o | m_err_o;
            tick();
            rst_i = ($urandom_range(0, 399) != 0);
            for (int i = 0; i < M; i++) begin
                if (!m_cyc_i[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        m_cyc_i[i]           = 1'b1;
                        m_stb_i[i]           = 1'b1;
                        m_adr_i[i*AW +: AW]  = rand_adr();
                        m_dat_i[i*DW +: DW]  = $urandom;
                        m_sel_i[i*SW +: SW]  = 4'($urandom);
                        m_we_i[i]            = 1'($urandom);
                    end
                end else if (resp[i]) begin
                    if ($urandom_range(0, 1) == 0) begin
                        m_cyc_i[i] = 1'b0;
                        m_stb_i[i] = 1'b0;
                    end else begin
                        m_stb_i[i]          = 1'b1;
                        m_adr_i[i*AW +: AW] = rand_adr();
                        m_dat_i[i*DW +: DW] = $urandom;
                        m_we_i[i]           = 1'($urandom);
                    end
                end else if ($urandom_range(0, 63) == 0) begin
                    m_cyc_i[i] = 1'b0;
                    m_stb_i[i] = 1'b0;
                end else if ($urandom_range(0, 15) == 0) begin
                    m_stb_i[i] = ~m_stb_i[i];
                end
            end
            for (int j = 0; j < S; j++) begin
                s_ack_i[j]          = ($urandom_range(0, 2) == 0);
                s_err_i[j]          = ($urandom_range(0, 15) == 0);
                s_dat_i[j*DW +: DW] = $urandom;
            end
        end

        @(negedge clk_i);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
